alu_issue_ctrl: RTL
===================

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1, meaning rising edges between driving ALU ports and capturing the result; legal range 1..15.
REQ-002 SHALL have ports, in order, as follows (clock and reset first):
- clk  input  1  single clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command.
- cmd_opcode  input  6  MIPS opcode field.
- cmd_funct  input  6  MIPS funct field; used only when cmd_opcode=000000.
- cmd_a  input  16  operand A (rs).
- cmd_b  input  16  operand B (rt or sign-extended immediate, prepared upstream).
- alu_op  output  4  operation code to the 16-bit ALU.
- alu_a, alu_b  output  16 each  ALU operands.
- alu_r  input  16  ALU result.
- alu_z  input  1  ALU zero flag.
- alu_o  input  1  ALU overflow flag.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts response.
- rsp_result  output  16  captured alu_r.
- rsp_wr  output  1  result shall be written to the register file.
- rsp_taken  output  1  branch taken.
- rsp_trap  output  1  arithmetic overflow trap.
- rsp_illegal  output  1  undecodable command.

Function
REQ-003 SHALL decode R-type (opcode 000000) funct: 100000 ADD->0010, 100010 SUB->0110, 100100 AND->0000, 100101 OR->0001, 100111 NOR->1100, 101010 SLT->0111, 101111 NAND->1101.
REQ-004 SHALL decode I-type opcodes: 001000 ADDI->0010, 001100 ANDI->0000, 001101 ORI->0001, 001010 SLTI->0111, 000100 BEQ->0110, 000101 BNE->0110.
REQ-005 SHALL treat every other opcode/funct combination as illegal.
REQ-006 SHALL implement FSM states IDLE, WAIT, RESP; cmd_ready=1 only in IDLE.
REQ-007 IDLE: on cmd_valid&cmd_ready at edge E0, SHALL register alu_op/alu_a/alu_b from decode and cmd_a/cmd_b, load settle counter with SETTLE_CYCLES, go to WAIT; illegal command SHALL instead go directly to RESP with rsp_illegal=1 and alu_* unchanged.
REQ-008 WAIT: counter decrements each edge; at edge E0+SETTLE_CYCLES SHALL capture alu_r/alu_z/alu_o into response registers and go to RESP.
REQ-009 RESP: rsp_valid=1 and all rsp_* stable until the edge where rsp_valid&rsp_ready; then go to IDLE; cmd_ready returns the following cycle (no same-cycle bypass).
REQ-010 alu_op/alu_a/alu_b SHALL hold their last value outside WAIT (no glitching on idle).
REQ-011 rsp_taken SHALL be alu_z for BEQ, ~alu_z for BNE, 0 otherwise.
REQ-012 rsp_trap SHALL be alu_o for ADD, SUB, ADDI; 0 for all others (SLT/branch overflow ignored).
REQ-013 rsp_wr SHALL be 1 only for legal non-branch commands with rsp_trap=0.
REQ-014 rsp_illegal=1 SHALL force rsp_wr=0, rsp_taken=0, rsp_trap=0, rsp_result=0.
REQ-015 cmd_* inputs SHALL be ignored when cmd_ready=0; alu_r/z/o ignored except at capture edge.
REQ-016 Legal-command latency: rsp_valid high in cycle after edge E0+SETTLE_CYCLES; illegal: after edge E0+1.

Reset
REQ-017 When reset=1 at an edge, SHALL enter IDLE, clear counter, and drive alu_op=0000, alu_a=alu_b=0, rsp_valid=0, all rsp_* =0; cmd_ready=0 while reset asserted, 1 in first cycle after.
REQ-018 Reset in WAIT or RESP SHALL abandon the command with no response emitted.

Verification
REQ-019 ADD, SETTLE=1: funct 100000, a=0x000C, b=0x0018, alu_r=0x0024 -> alu_op=0010, rsp_result=0x0024, rsp_wr=1, rsp_valid one cycle after accept edge+1.
REQ-020 ADD overflow: a=0x7FFF, b=0x0001, alu_o=1 -> rsp_trap=1, rsp_wr=0; same with SLT (a=0x8000,b=0x0001) -> rsp_trap=0, rsp_wr=1.
REQ-021 BEQ/BNE: a=b=0x1234, alu_z=1 -> BEQ rsp_taken=1, BNE rsp_taken=0, rsp_wr=0, alu_op=0110.
REQ-022 Illegal opcode 111111 -> rsp_illegal=1 after one edge, alu_* unchanged, rsp_wr=0.
REQ-023 Backpressure, SETTLE=3: rsp_ready=0 for 5 cycles -> rsp_* stable, cmd_ready=0, second cmd_valid not accepted; accepted one cycle after release.
REQ-024 Reset asserted in WAIT -> next cycle all outputs zero, no rsp_valid, cmd_ready=1 after deassertion.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl
//   Takes one MIPS-style command at a time, decodes opcode/funct into a 4-bit
//   ALU operation, holds the operands on the ALU ports for SETTLE_CYCLES
//   rising edges, then captures the ALU result and flags into a response.
//   The response is held until the consumer accepts it. Commands that cannot
//   be decoded skip the ALU and respond at once with rsp_illegal set.
//
// Parameter
//   SETTLE_CYCLES  rising edges from driving the ALU ports to capture (1..15)
//
// Ports
//   clk, reset                     clock, synchronous active-high reset
//   cmd_valid/cmd_ready            command handshake
//   cmd_opcode, cmd_funct          MIPS opcode / funct fields
//   cmd_a, cmd_b                   16-bit operands
//   alu_op, alu_a, alu_b           registered drive to the external ALU
//   alu_r, alu_z, alu_o            ALU result, zero flag, overflow flag
//   rsp_valid/rsp_ready            response handshake
//   rsp_result                     captured ALU result
//   rsp_wr, rsp_taken              register write enable, branch taken
//   rsp_trap, rsp_illegal          overflow trap, undecodable command
//
// States
//   state   | meaning
//   IDLE    | ready for a command, ALU ports hold their last value
//   WAIT    | ALU ports driven, settle down-counter running
//   RESP    | response presented, waiting for rsp_ready
// ---------------------------------------------------------------------------
module alu_issue_ctrl #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [5:0]  cmd_opcode,
  input  logic [5:0]  cmd_funct,
  input  logic [15:0] cmd_a,
  input  logic [15:0] cmd_b,
  output logic [3:0]  alu_op,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  input  logic [15:0] alu_r,
  input  logic        alu_z,
  input  logic        alu_o,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic        rsp_wr,
  output logic        rsp_taken,
  output logic        rsp_trap,
  output logic        rsp_illegal
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

  logic [1:0] state;
  logic [3:0] settle_cnt;

  logic       dec_legal;
  logic [3:0] dec_op;
  logic       dec_trap_en;
  logic       dec_beq;
  logic       dec_bne;

  // Command class remembered across WAIT so the flags can be formed at capture.
  logic       pend_trap_en;
  logic       pend_beq;
  logic       pend_bne;

  logic       accept;
  logic       cap_trap;

  always_comb begin
    dec_legal   = 1'b0;
    dec_op      = 4'b0000;
    dec_trap_en = 1'b0;
    dec_beq     = 1'b0;
    dec_bne     = 1'b0;
    case (cmd_opcode)
      6'b000000: begin
        dec_legal = 1'b1;
        case (cmd_funct)
          6'b100000: begin dec_op = 4'b0010; dec_trap_en = 1'b1; end
          6'b100010: begin dec_op = 4'b0110; dec_trap_en = 1'b1; end
          6'b100100: dec_op = 4'b0000;
          6'b100101: dec_op = 4'b0001;
          6'b100111: dec_op = 4'b1100;
          6'b101010: dec_op = 4'b0111;
          6'b101111: dec_op = 4'b1101;
          default:   dec_legal = 1'b0;
        endcase
      end
      6'b001000: begin dec_legal = 1'b1; dec_op = 4'b0010; dec_trap_en = 1'b1; end
      6'b001100: begin dec_legal = 1'b1; dec_op = 4'b0000; end
      6'b001101: begin dec_legal = 1'b1; dec_op = 4'b0001; end
      6'b001010: begin dec_legal = 1'b1; dec_op = 4'b0111; end
      6'b000100: begin dec_legal = 1'b1; dec_op = 4'b0110; dec_beq = 1'b1; end
      6'b000101: begin dec_legal = 1'b1; dec_op = 4'b0110; dec_bne = 1'b1; end
      default:   dec_legal = 1'b0;
    endcase
  end

  // Ready is masked by reset so nothing looks acceptable while reset is held.
  assign cmd_ready = (state == ST_IDLE) && !reset;
  assign accept    = cmd_valid && cmd_ready;
  assign rsp_valid = (state == ST_RESP);
  assign cap_trap  = pend_trap_en && alu_o;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      settle_cnt   <= 4'd0;
      alu_op       <= 4'b0000;
      alu_a        <= 16'h0000;
      alu_b        <= 16'h0000;
      pend_trap_en <= 1'b0;
      pend_beq     <= 1'b0;
      pend_bne     <= 1'b0;
      rsp_result   <= 16'h0000;
      rsp_wr       <= 1'b0;
      rsp_taken    <= 1'b0;
      rsp_trap     <= 1'b0;
      rsp_illegal  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (dec_legal) begin
              alu_op       <= dec_op;
              alu_a        <= cmd_a;
              alu_b        <= cmd_b;
              pend_trap_en <= dec_trap_en;
              pend_beq     <= dec_beq;
              pend_bne     <= dec_bne;
              settle_cnt   <= SETTLE_INIT;
              state        <= ST_WAIT;
            end else begin
              // ALU ports deliberately left untouched for illegal commands.
              rsp_result  <= 16'h0000;
              rsp_wr      <= 1'b0;
              rsp_taken   <= 1'b0;
              rsp_trap    <= 1'b0;
              rsp_illegal <= 1'b1;
              state       <= ST_RESP;
            end
          end
        end
        ST_WAIT: begin
          // Terminal count 1: this edge is the SETTLE_CYCLES-th after accept.
          if (settle_cnt == 4'd1) begin
            settle_cnt  <= 4'd0;
            rsp_result  <= alu_r;
            rsp_taken   <= (pend_beq && alu_z) || (pend_bne && !alu_z);
            rsp_trap    <= cap_trap;
            rsp_wr      <= !pend_beq && !pend_bne && !cap_trap;
            rsp_illegal <= 1'b0;
            state       <= ST_RESP;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
